// File: rtl/l2_reduce_accumulator.sv
// -----------------------------------------------------------------------------
// l2_reduce_accumulator
//
// Second-level reduction stage behind the L1 adder array. Each cycle it can
// take one vector of array_size unsigned partial sums. A registered binary
// adder tree reduces the vector to one scalar. The block then accumulates
// pass_count consecutive scalars into one saturating convolution result. The
// result is presented with a one-cycle out_valid pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   enable     global advance; when low every register holds
//   clear      synchronous abort of in-flight beats and partial accumulation
//   in_valid   in_num carries a valid L1 result this cycle
//   in_num     array_size packed unsigned lanes of data_width+1 bits, lane 0 at LSB
//   out_num    accumulated result, qualified by out_valid, held between pulses
//   out_valid  one-cycle pulse per completed accumulation
//   overflow   out_num saturated during this accumulation, qualified by out_valid
//   busy       a beat is in the tree or a partial accumulation is held
//   fsm_state  accumulator FSM state (0 IDLE, 1 ACCUM, 2 DONE) for observation
//
// Handshake: there is no back-pressure. A beat is accepted on every rising
// edge where enable=1, in_valid=1 and clear=0. The out_valid pulse is
// presented for exactly one enabled cycle. If enable drops while out_valid is
// high, out_valid stays high until the next enabled edge.
// -----------------------------------------------------------------------------
module l2_reduce_accumulator #(
  parameter int data_width = 16,
  parameter int array_size = 8,   // power of two, >= 2
  parameter int pass_count = 9,
  parameter int acc_width  = 32   // >= data_width + 1 + log2(array_size)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 clear,
  input  logic                                 in_valid,
  input  logic [array_size*(data_width+1)-1:0] in_num,
  output logic [acc_width-1:0]                 out_num,
  output logic                                 out_valid,
  output logic                                 overflow,
  output logic                                 busy,
  output logic [1:0]                           fsm_state
);

  localparam int lane_w = data_width + 1;
  localparam int levels = $clog2(array_size);
  localparam int sum_w  = lane_w + levels;
  localparam int cnt_w  = $clog2(pass_count + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Adder tree, heap-indexed. Node 1 is the root. Internal nodes 1..array_size-1
  // are registered. The leaves array_size..2*array_size-1 are the input lanes.
  // Node j adds children 2j and 2j+1, so every root-to-leaf path crosses exactly
  // `levels` registers. All nodes use the final width, which avoids truncation.
  // ---------------------------------------------------------------------------
  logic [sum_w-1:0]  tree_q [1:array_size-1];
  logic [sum_w-1:0]  tree_d [1:array_size-1];
  logic [sum_w-1:0]  node   [2:2*array_size-1];
  logic [levels-1:0] vld_q;

  always_comb begin
    for (int j = 2; j < array_size; j++) begin
      node[j] = tree_q[j];
    end
    for (int j = 0; j < array_size; j++) begin
      node[array_size + j] = sum_w'(in_num[j*lane_w +: lane_w]);
    end
    for (int j = 1; j < array_size; j++) begin
      tree_d[j] = node[2*j] + node[2*j + 1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 1; j < array_size; j++) begin
        tree_q[j] <= '0;
      end
      vld_q <= '0;
    end else if (enable) begin
      for (int j = 1; j < array_size; j++) begin
        tree_q[j] <= tree_d[j];
      end
      // Valid shifts one level per cycle. The cast drops the bit leaving the root.
      vld_q <= clear ? '0 : levels'({vld_q, in_valid});
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating accumulator
  // ---------------------------------------------------------------------------
  state_t               state_q;
  logic [acc_width-1:0] acc_q;
  logic [cnt_w-1:0]     count_q;
  logic                 sticky_q;

  logic                 tree_valid;
  logic [acc_width-1:0] sum_ext;
  logic [acc_width:0]   acc_sum;
  logic [acc_width-1:0] acc_next;
  logic                 sticky_next;
  logic                 last_beat;

  assign tree_valid  = vld_q[levels-1];
  assign sum_ext     = acc_width'(tree_q[1]);
  assign acc_sum     = {1'b0, acc_q} + {1'b0, sum_ext};
  assign acc_next    = acc_sum[acc_width] ? '1 : acc_sum[acc_width-1:0];
  assign sticky_next = sticky_q | acc_sum[acc_width];
  assign last_beat   = (count_q == cnt_w'(pass_count - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      sticky_q  <= 1'b0;
      out_num   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (enable) begin
      out_valid <= 1'b0;
      if (clear) begin
        // The out_valid of a DONE cycle is already on the port, so it is kept.
        state_q  <= IDLE;
        acc_q    <= '0;
        count_q  <= '0;
        sticky_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            // In DONE, a beat that arrives immediately starts the next
            // accumulation, so back-to-back groups lose no beat.
            if (tree_valid) begin
              acc_q    <= sum_ext;
              count_q  <= cnt_w'(1);
              sticky_q <= 1'b0;
              if (pass_count == 1) begin
                state_q   <= DONE;
                out_valid <= 1'b1;
                out_num   <= sum_ext;
                overflow  <= 1'b0;
              end else begin
                state_q <= ACCUM;
              end
            end else begin
              state_q  <= IDLE;
              acc_q    <= '0;
              count_q  <= '0;
              sticky_q <= 1'b0;
            end
          end
          ACCUM: begin
            if (tree_valid) begin
              acc_q    <= acc_next;
              sticky_q <= sticky_next;
              if (last_beat) begin
                state_q   <= DONE;
                count_q   <= cnt_w'(pass_count);
                out_valid <= 1'b1;
                out_num   <= acc_next;
                overflow  <= sticky_next;
              end else begin
                count_q <= count_q + cnt_w'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (|vld_q) || (state_q == ACCUM);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_l2_reduce_accumulator.sv
// -----------------------------------------------------------------------------
// tb_l2_reduce_accumulator
//
// Two instances share all stimulus: dut uses the default 32-bit accumulator,
// and dut_s uses a 20-bit accumulator so that saturation can be reached.
// Directed groups push hand-computed results, with the cycle each result is
// due, into one queue per instance. A monitor pops an entry on every out_valid
// pulse and compares it.
// -----------------------------------------------------------------------------
module tb_l2_reduce_accumulator;

  localparam int dw = 136;  // 8 lanes x 17 bits

  logic          clk;
  logic          reset;
  logic          enable;
  logic          clear;
  logic          in_valid;
  logic [dw-1:0] in_num;

  logic [31:0] out_num;
  logic        out_valid, overflow, busy;
  logic [1:0]  fsm_state;
  logic [19:0] out_num_s;
  logic        out_valid_s, overflow_s, busy_s;
  logic [1:0]  fsm_state_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Each entry is {overflow, value, due cycle}.
  logic [64:0] exp_q[$];
  logic [64:0] exp_s_q[$];

  l2_reduce_accumulator dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_num(in_num),
    .out_num(out_num), .out_valid(out_valid), .overflow(overflow),
    .busy(busy), .fsm_state(fsm_state)
  );

  l2_reduce_accumulator #(.acc_width(20)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_num(in_num),
    .out_num(out_num_s), .out_valid(out_valid_s), .overflow(overflow_s),
    .busy(busy_s), .fsm_state(fsm_state_s)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [dw-1:0] all_lanes(input logic [16:0] v);
    logic [dw-1:0] d;
    for (int i = 0; i < 8; i++) d[i*17 +: 17] = v;
    return d;
  endfunction

  function automatic logic [dw-1:0] index_lanes();
    logic [dw-1:0] d;
    for (int i = 0; i < 8; i++) d[i*17 +: 17] = 17'(i);
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic beat(input logic [dw-1:0] d);
    enable   = 1'b1;
    in_valid = 1'b1;
    in_num   = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called in the cycle of the last beat of a group; the pulse is due 4 cycles later.
  task automatic expect_out(input logic [31:0] v32, input logic o32,
                            input logic [31:0] v20, input logic o20);
    exp_q.push_back({o32, v32, 32'(cyc + 4)});
    exp_s_q.push_back({o20, v20, 32'(cyc + 4)});
  endtask

  task automatic group9(input logic [dw-1:0] d, input logic [31:0] v32, input logic o32,
                        input logic [31:0] v20, input logic o20);
    for (int i = 0; i < 8; i++) beat(d);
    expect_out(v32, o32, v20, o20);
    beat(d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_num"}, 64'(out_num), 0);
    check({tag, "_out_valid"}, 64'(out_valid), 0);
    check({tag, "_overflow"}, 64'(overflow), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_state"}, 64'(fsm_state), 0);
    check({tag, "_out_num_s"}, 64'(out_num_s), 0);
    check({tag, "_out_valid_s"}, 64'(out_valid_s), 0);
    check({tag, "_busy_s"}, 64'(busy_s), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'(out_num), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_num", 64'(out_num), 64'(e[63:32]));
          check("overflow", 64'(overflow), 64'(e[64]));
          check("pulse_cycle", 64'(cyc), 64'(e[31:0]));
        end
      end
      if (out_valid_s) begin
        if (exp_s_q.size() == 0) begin
          check("unexpected_pulse_s", 64'(out_num_s), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_s_q.pop_front();
          check("out_num_s", 64'(out_num_s), 64'(e[63:32]));
          check("overflow_s", 64'(overflow_s), 64'(e[64]));
          check("pulse_cycle_s", 64'(cyc), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_num   = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    idle(2);

    // Nine beats of all-ones lanes: 9 * 8 = 72.
    group9(all_lanes(17'd1), 32'd72, 1'b0, 32'd72, 1'b0);
    idle(8);
    check("t1_busy_after", 64'(busy), 0);
    check("t1_state_after", 64'(fsm_state), 0);
    check("t1_out_num_held", 64'(out_num), 72);

    // Back-to-back groups: lane i = i gives 28 per beat -> 252, then all
    // 0x1FFFF gives 9*8*131071 = 9437112, which saturates the 20-bit copy.
    group9(index_lanes(), 32'd252, 1'b0, 32'd252, 1'b0);
    group9(all_lanes(17'h1FFFF), 32'd9437112, 1'b0, 32'hFFFFF, 1'b1);
    idle(8);
    check("t2_overflow_s_held", 64'(overflow_s), 1);

    // Saturation, followed by a clean accumulation that must clear the flag.
    group9(all_lanes(17'h1FFFF), 32'd9437112, 1'b0, 32'hFFFFF, 1'b1);
    group9(all_lanes(17'd1), 32'd72, 1'b0, 32'd72, 1'b0);
    idle(8);

    // Five beats, then clear with in_valid high, then a full group of twos.
    for (int i = 0; i < 5; i++) beat(all_lanes(17'd1));
    clear = 1'b1;
    beat(all_lanes(17'd1));
    clear = 1'b0;
    check("t4_busy_after_clear", 64'(busy), 0);
    check("t4_state_after_clear", 64'(fsm_state), 0);
    group9(all_lanes(17'd2), 32'd144, 1'b0, 32'd144, 1'b0);
    idle(8);

    // Enable low for three cycles mid-stream while in_valid carries junk.
    for (int i = 0; i < 4; i++) beat(all_lanes(17'd1));
    enable   = 1'b0;
    in_valid = 1'b1;
    in_num   = all_lanes(17'd5);
    repeat (3) @(negedge clk);
    check("t5_busy_frozen", 64'(busy), 1);
    enable   = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) beat(all_lanes(17'd1));
    expect_out(32'd72, 1'b0, 32'd72, 1'b0);
    beat(all_lanes(17'd1));
    idle(8);

    // Asynchronous reset after four beats; the partial result is lost.
    for (int i = 0; i < 4; i++) beat(all_lanes(17'd1));
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    group9(all_lanes(17'd3), 32'd216, 1'b0, 32'd216, 1'b0);
    idle(10);

    check("pending_results", 64'(exp_q.size()), 0);
    check("pending_results_s", 64'(exp_s_q.size()), 0);
    check("final_busy", 64'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
